// File: rtl/ch_split4.sv
// Downlink 4-channel I/Q splitter: frame-locks an interleaved 18-bit stream, rounds and
// saturates each sample to 16 bits and routes it to one of four per-channel registers.

module ch_split4_scale #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);
  localparam int RND_I = (SHIFT == 0) ? 0 : (1 << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic signed [IN_W:0] RND    = (IN_W+1)'(RND_I);
  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'((1 << (OUT_W-1)) - 1);

  logic signed [IN_W:0] sum, sh;

  // one guard bit so the rounding add can never wrap
  assign sum = $signed({x[IN_W-1], x}) + RND;
  assign sh  = sum >>> SHIFT;

  always_comb begin
    if (sh > SAT_HI)       y = SAT_HI[OUT_W-1:0];
    else if (sh < ~SAT_HI) y = {1'b1, {(OUT_W-1){1'b0}}};
    else                   y = sh[OUT_W-1:0];
  end
endmodule

module ch_split4_lane #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [OUT_W-1:0] din_i,
  input  logic [OUT_W-1:0] din_q,
  output logic [OUT_W-1:0] dout_i,
  output logic [OUT_W-1:0] dout_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_i <= '0;
      dout_q <= '0;
    end else if (we) begin
      dout_i <= din_i;
      dout_q <= din_q;
    end
  end
endmodule

module ch_split4 #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_in_i,
  input  logic [IN_W-1:0]  data_in_q,
  input  logic             valid_in,
  input  logic             sof_in,
  output logic [OUT_W-1:0] data_ch0_i,
  output logic [OUT_W-1:0] data_ch0_q,
  output logic [OUT_W-1:0] data_ch1_i,
  output logic [OUT_W-1:0] data_ch1_q,
  output logic [OUT_W-1:0] data_ch2_i,
  output logic [OUT_W-1:0] data_ch2_q,
  output logic [OUT_W-1:0] data_ch3_i,
  output logic [OUT_W-1:0] data_ch3_q,
  output logic [3:0]       ch_strobe,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);
  localparam int NUM_CH = 4;
  localparam int STAGES = 2;

  typedef enum logic {HUNT, RUN} state_t;
  typedef struct packed {
    logic [IN_W-1:0] i;
    logic [IN_W-1:0] q;
  } iq_in_t;
  typedef struct packed {
    logic [OUT_W-1:0] i;
    logic [OUT_W-1:0] q;
  } iq_out_t;

  state_t        state, state_n;
  logic [1:0]    cnt, cnt_n;
  logic          acc, err;
  logic [1:0]    acc_ch;
  logic [STAGES:1] vld_pipe;
  iq_in_t        s1_smp;
  logic [1:0]    s1_ch, s2_ch;
  iq_out_t       s2_din;
  logic [NUM_CH-1:0][OUT_W-1:0] ch_i, ch_q;

  // framing FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (valid_in) begin
      case (state)
        HUNT: if (sof_in) begin
          state_n = RUN;
          cnt_n   = 2'd1;
        end
        RUN: begin
          if (sof_in)            cnt_n = 2'd1;
          else if (cnt != 2'd0)  cnt_n = cnt + 2'd1;
          else begin
            state_n = HUNT;
            cnt_n   = 2'd0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_comb begin
    acc    = 1'b0;
    acc_ch = 2'd0;
    err    = 1'b0;
    if (valid_in) begin
      case (state)
        HUNT: acc = sof_in;
        RUN: begin
          if (sof_in) begin
            acc = 1'b1;
            err = (cnt != 2'd0);
          end else if (cnt != 2'd0) begin
            acc    = 1'b1;
            acc_ch = cnt;
          end else begin
            err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign locked = (state == RUN);

  // stage 1: capture accepted sample and its channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_smp   <= '0;
      s1_ch    <= '0;
      s2_ch    <= '0;
      sync_err <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      sync_err <= err;
      s2_ch    <= s1_ch;
      if (acc) begin
        s1_smp <= '{i: data_in_i, q: data_in_q};
        s1_ch  <= acc_ch;
      end
    end
  end

  // stage 2: scale and write the selected lane
  ch_split4_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT))
    u_scale_i (.x(s1_smp.i), .y(s2_din.i));
  ch_split4_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT))
    u_scale_q (.x(s1_smp.q), .y(s2_din.q));

  for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
    ch_split4_lane #(.OUT_W(OUT_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we     (vld_pipe[1] && (s1_ch == 2'(n))),
      .din_i  (s2_din.i),
      .din_q  (s2_din.q),
      .dout_i (ch_i[n]),
      .dout_q (ch_q[n])
    );
  end

  assign ch_strobe  = vld_pipe[2] ? (4'b0001 << s2_ch) : 4'b0000;
  assign frame_done = vld_pipe[2] && (s2_ch == 2'd3);

  assign data_ch0_i = ch_i[0];
  assign data_ch0_q = ch_q[0];
  assign data_ch1_i = ch_i[1];
  assign data_ch1_q = ch_q[1];
  assign data_ch2_i = ch_i[2];
  assign data_ch2_q = ch_q[2];
  assign data_ch3_i = ch_i[3];
  assign data_ch3_q = ch_q[3];
endmodule

// File: tb/tb_ch_split4.sv
// Randomized scoreboard bench for ch_split4 with a frame-level reference model.

module tb_ch_split4;
  localparam int IN_W  = 18;
  localparam int OUT_W = 16;
  localparam int SHIFT = 2;

  typedef struct {
    int cyc;
    int ch;
    int i;
    int q;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [IN_W-1:0] din_i = '0, din_q = '0;
  logic valid_in = 1'b0, sof_in = 1'b0;
  logic signed [OUT_W-1:0] oi [4];
  logic signed [OUT_W-1:0] oq [4];
  logic [OUT_W-1:0] d0i, d0q, d1i, d1q, d2i, d2q, d3i, d3q;
  logic [3:0] ch_strobe;
  logic frame_done, locked, sync_err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  ev_t exp_q[$];
  ev_t sync_q[$];
  ev_t lock_q[$];
  int exp_locked = 0;
  int m_lock = 0;
  int m_cnt = 0;

  ch_split4 #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .data_in_i(din_i), .data_in_q(din_q),
    .valid_in(valid_in), .sof_in(sof_in),
    .data_ch0_i(d0i), .data_ch0_q(d0q),
    .data_ch1_i(d1i), .data_ch1_q(d1q),
    .data_ch2_i(d2i), .data_ch2_q(d2q),
    .data_ch3_i(d3i), .data_ch3_q(d3q),
    .ch_strobe(ch_strobe), .frame_done(frame_done),
    .locked(locked), .sync_err(sync_err)
  );

  assign oi[0] = d0i; assign oq[0] = d0q;
  assign oi[1] = d1i; assign oq[1] = d1q;
  assign oi[2] = d2i; assign oq[2] = d2q;
  assign oi[3] = d3i; assign oq[3] = d3q;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int scale(input int x);
    int r;
    r = (x + ((SHIFT == 0) ? 0 : (1 << (SHIFT - 1)))) >>> SHIFT;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // reference: what each valid sample should produce, and when
  task automatic model(input int x_i, input int x_q, input logic sof, input int c);
    ev_t e;
    int ch = -1;
    if (m_lock == 0) begin
      if (sof) begin ch = 0; m_lock = 1; m_cnt = 1; end
    end else if (sof) begin
      if (m_cnt != 0) sync_q.push_back('{c + 1, 0, 0, 0});
      ch = 0; m_cnt = 1;
    end else if (m_cnt != 0) begin
      ch = m_cnt; m_cnt = (m_cnt + 1) % 4;
    end else begin
      sync_q.push_back('{c + 1, 0, 0, 0});
      m_lock = 0;
    end
    lock_q.push_back('{c + 1, m_lock, 0, 0});
    if (ch >= 0) begin
      e = '{c + 2, ch, scale(x_i), scale(x_q)};
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int x_i, input int x_q, input logic sof);
    @(posedge clk); #1;
    din_i = IN_W'(x_i); din_q = IN_W'(x_q);
    valid_in = 1'b1; sof_in = sof;
    model(x_i, x_q, sof, cyc);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      sof_in = ($urandom_range(0, 1) == 1);
      din_i = IN_W'($urandom);
    end
  endtask

  task automatic chk_zero();
    for (int n = 0; n < 4; n++) begin
      chk("rst_data_i", oi[n], 0);
      chk("rst_data_q", oq[n], 0);
    end
    chk("rst_strobe", ch_strobe, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sync_err", sync_err, 0);
  endtask

  function automatic int rnd_val();
    logic signed [IN_W-1:0] r;
    case ($urandom_range(0, 7))
      0: return 131071;
      1: return -131072;
      2: return 131069;
      3: return -131070;
      default: begin r = IN_W'($urandom); return int'(r); end
    endcase
  endfunction

  // monitor: compare every DUT presentation against the scoreboard
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      while (lock_q.size() > 0 && lock_q[0].cyc <= cyc) begin
        exp_locked = lock_q[0].ch;
        void'(lock_q.pop_front());
      end
      chk("locked", locked, exp_locked);

      if (ch_strobe != 0 || frame_done) begin
        if (exp_q.size() == 0) chk("spurious_strobe", ch_strobe, 0);
        else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe", ch_strobe, 1 << e.ch);
          chk("frame_done", frame_done, (e.ch == 3) ? 1 : 0);
          chk("data_i", oi[e.ch], e.i);
          chk("data_q", oq[e.ch], e.q);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_strobe", ch_strobe, 1 << exp_q[0].ch);
        void'(exp_q.pop_front());
      end

      if (sync_err) begin
        if (sync_q.size() > 0 && sync_q[0].cyc == cyc) begin
          chk("sync_err", sync_err, 1);
          void'(sync_q.pop_front());
        end else chk("spurious_sync_err", sync_err, 0);
      end else if (sync_q.size() > 0 && sync_q[0].cyc <= cyc) begin
        chk("missing_sync_err", sync_err, 1);
        void'(sync_q.pop_front());
      end
    end
  end

  initial begin
    int pos;
    logic sof;
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    rst = 1'b0;

    // clean frame
    send(6, 0, 1); send(-6, 0, 0); send(400, 0, 0); send(-400, 0, 0);
    idle(3);
    chk("clean_ch0_i", oi[0], 2);
    chk("clean_ch1_i", oi[1], -1);
    chk("clean_ch2_i", oi[2], 100);
    chk("clean_ch3_i", oi[3], -100);

    // saturation
    send(131071, 5, 1); send(-131072, -5, 0); send(7, 131069, 0); send(-131070, 0, 0);
    idle(3);
    chk("sat_ch0_i", oi[0], 32767);
    chk("sat_ch1_i", oi[1], -32768);
    chk("sat_ch2_q", oq[2], 32767);

    // gaps between ch1 and ch2
    send(100, 200, 1); send(300, 400, 0); idle(3); send(500, 600, 0); send(700, 800, 0);
    idle(2);

    // early SOF on 3rd sample, then continue
    send(11, 12, 1); send(13, 14, 0); send(15, 16, 1); send(17, 18, 0);
    send(19, 20, 0); send(21, 22, 0);
    idle(2);

    // missing SOF on 5th sample, drops until next SOF
    send(31, 32, 1); send(33, 34, 0); send(35, 36, 0); send(37, 38, 0);
    send(39, 40, 0); send(41, 42, 0); send(43, 44, 0);
    send(45, 46, 1); send(47, 48, 0); send(49, 50, 0); send(51, 52, 0);
    idle(2);

    // async reset with samples in flight
    send(1000, 2000, 1); send(3000, 4000, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero();
    exp_q.delete(); sync_q.delete(); lock_q.delete();
    m_lock = 0; m_cnt = 0; exp_locked = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(5000, 6000, 0); send(7000, 8000, 0);
    send(123, 456, 1); send(-123, -456, 0); send(99, -99, 0); send(8, -8, 0);
    idle(3);

    // randomized traffic with occasional framing faults
    pos = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        sof = (pos == 0);
        if ($urandom_range(0, 24) == 0) sof = !sof;
        pos = sof ? 1 : (pos + 1) % 4;
        send(rnd_val(), rnd_val(), sof);
      end
    end
    idle(6);
    chk("leftover_strobes", exp_q.size(), 0);
    chk("leftover_sync_err", sync_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ch_split4.md
Name: ch_split4

Overview:
- Downlink-side counterpart of the uplink 4-channel I/Q combiner.
- Accepts a single 18-bit I/Q stream carrying four channels time-interleaved (ch0, ch1, ch2, ch3, ch0, …), with a start-of-frame marker on ch0.
- Locks to the frame, scales each sample back to 16 bits with rounding and saturation, and routes it to one of four per-channel 16-bit I/Q output registers with per-channel strobes.
- Sits between the downlink DSP chain and the per-channel demodulators.

Parameters:
- IN_W, 18, input sample width (signed two's complement).
- OUT_W, 16, output sample width per channel (signed).
- SHIFT, 2, arithmetic right shift applied before saturation, legal range 0..4.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in_i  in  IN_W  interleaved I sample
- data_in_q  in  IN_W  interleaved Q sample
- valid_in  in  1  sample qualifier; one sample per cycle with valid_in=1
- sof_in  in  1  marks ch0 sample; ignored when valid_in=0
- data_ch0_i / data_ch0_q  out  OUT_W  channel 0 I/Q
- data_ch1_i / data_ch1_q  out  OUT_W  channel 1 I/Q
- data_ch2_i / data_ch2_q  out  OUT_W  channel 2 I/Q
- data_ch3_i / data_ch3_q  out  OUT_W  channel 3 I/Q
- ch_strobe  out  4  one-cycle pulse, bit n = channel n registers updated this cycle
- frame_done  out  1  one-cycle pulse coincident with ch_strobe[3]
- locked  out  1  high while FSM in RUN
- sync_err  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset (async, rst=1): all data_ch* = 0, ch_strobe = 0, frame_done = 0, sync_err = 0, locked = 0, FSM = HUNT, channel counter = 0, pipeline valids cleared. In-flight samples are discarded, never delivered after reset release.
- Pipeline: stage 1 registers sample, channel index, accepted flag. Stage 2 performs scale/saturate and writes the target channel register.
- Latency: sample accepted at edge N appears on data_chN and its ch_strobe pulses after edge N+2. Full throughput, one sample per clock, no backpressure.
- Scaling, I and Q independently: r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits with no overflow; the rounding term is 0 when SHIFT=0.
- Saturation: r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Non-selected channel registers hold their value.
- FSM HUNT:
  - valid_in=1 & sof_in=1 → sample accepted as ch0, counter=1, go RUN.
  - Any other valid sample dropped, no strobe.
- FSM RUN, on each valid_in=1:
  - counter==0 & sof_in=1 → accept as ch0, counter=1.
  - counter!=0 & sof_in=0 → accept as ch[counter], counter increments, 3 wraps to 0.
  - counter!=0 & sof_in=1 (early SOF) → sync_err pulse, accept as ch0, counter=1, stay RUN (resync).
  - counter==0 & sof_in=0 (missing SOF) → sync_err pulse, sample dropped, go HUNT, counter=0.
- valid_in=0 cycles: no state change, gaps between samples are allowed.
- sync_err is asserted 1 cycle after the offending input edge, i.e. registered at stage 1.
- locked = (FSM == RUN), registered and updated with the FSM.
- frame_done pulses only when ch3 is written, never on partial frames cut by resync.

Test Plan:
- Reset then a clean frame, SHIFT=2:
  - Stimulus: sof on first sample; I = 6, -6, 400, -400; Q = 0.
  - Required: ch0_i=2, ch1_i=-1, ch2_i=100, ch3_i=-100.
  - ch_strobe sequence 0001, 0010, 0100, 1000 starting 2 cycles after the first valid; frame_done with 1000; locked high from cycle after SOF.
- Saturation:
  - Stimulus: ch0 I=131071, ch1 I=-131072, ch2 Q=131069.
  - Required: ch0_i=32767, ch1_i=-32768, ch2_q=32767.
- Gaps: insert 3 idle cycles (valid_in=0) between ch1 and ch2 → channel mapping unchanged, no extra strobes, frame_done still on ch3.
- Early SOF: sof_in asserted on the 3rd sample of a frame → sync_err pulse, that sample lands in ch0, next sample lands in ch1, locked stays 1.
- Missing SOF: 5th sample arrives with sof_in=0 → sync_err pulse, no strobe for it, locked drops, subsequent samples dropped until the next SOF.
- Async reset mid-frame: assert rst between ch1 and ch2 with samples in the pipeline → outputs go to 0 immediately, no strobe after release; after release block in HUNT until SOF.
